// File: rtl/tagged_multicaster.sv
// Tagged multicast engine: buffers bus words in a small FIFO and delivers each one to every
// targeted PE column, retiring it only once all targets have handshaken.
module tagged_multicaster #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_COL),
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_COL)-1:0] cfg_col,
  input  logic [ID_WIDTH-1:0]        cfg_id,
  input  logic                       cfg_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [ID_WIDTH-1:0]        in_tag,
  input  logic [1:0]                 in_mode,
  output logic [DATA_WIDTH-1:0]      pe_data,
  output logic [NUM_COL-1:0]         pe_valid,
  input  logic [NUM_COL-1:0]         pe_ready,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   tag_mem  [FIFO_DEPTH];
  logic [1:0]            mode_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  in_ready_q;
  logic                  push, pop;

  logic [ID_WIDTH-1:0]   col_id_q [NUM_COL];
  logic [NUM_COL-1:0]    col_en_q;
  logic [NUM_COL-1:0]    head_mask, pending_q, pending_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           drop_q, drop_d;

  assign push     = in_valid & in_ready_q;
  assign in_ready = in_ready_q;
  assign pe_data  = data_q;
  assign pe_valid = pending_q;
  assign drop_cnt = drop_q;
  assign busy     = (count_q != '0) | (state_q == StSend);

  // Payload storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= in_data;
      tag_mem[wr_ptr_q]  <= in_tag;
      mode_mem[wr_ptr_q] <= in_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COL; i++) begin
        col_id_q[i] <= ID_WIDTH'(i);
      end
      col_en_q <= '1;
    end else if (cfg_we) begin
      col_id_q[cfg_col] <= cfg_id;
      col_en_q[cfg_col] <= cfg_en;
    end
  end

  always_comb begin
    head_mask = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      case (mode_mem[rd_ptr_q])
        2'b00:   head_mask[i] = col_en_q[i] & (col_id_q[i] == tag_mem[rd_ptr_q]);
        2'b01:   head_mask[i] = col_en_q[i];
        2'b10:   head_mask[i] = col_en_q[i] & (tag_mem[rd_ptr_q] == ID_WIDTH'(i));
        default: head_mask[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    data_d    = data_q;
    drop_d    = drop_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          if (|head_mask) begin
            pending_d = head_mask;
            data_d    = data_mem[rd_ptr_q];
            state_d   = StSend;
          end else begin
            pop = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end
        end
      end
      StSend: begin
        // The head stays in the FIFO until every target has accepted it.
        if ((pending_q & ~pe_ready) == '0) begin
          pop       = 1'b1;
          pending_d = '0;
          state_d   = StIdle;
        end else begin
          pending_d = pending_q & ~pe_ready;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      data_q     <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      in_ready_q <= (count_d < CntW'(FIFO_DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

endmodule

// File: tb/tb_tagged_multicaster.sv
// Bench for tagged_multicaster: directed steps plus a randomized phase, checked against an
// ordered per-word delivery model.
module tb_tagged_multicaster;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_col = '0;
  logic [1:0]  cfg_id = '0;
  logic        cfg_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_tag = '0;
  logic [1:0]  in_mode = '0;
  logic [15:0] pe_data;
  logic [3:0]  pe_valid;
  logic [3:0]  pe_ready = '1;
  logic        busy;
  logic [15:0] drop_cnt;

  tagged_multicaster #(
    .DATA_WIDTH(16),
    .NUM_COL   (NC),
    .ID_WIDTH  (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_col (cfg_col),
    .cfg_id  (cfg_id),
    .cfg_en  (cfg_en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_tag  (in_tag),
    .in_mode (in_mode),
    .pe_data (pe_data),
    .pe_valid(pe_valid),
    .pe_ready(pe_ready),
    .busy    (busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mask;
  } word_t;

  int n_cmp = 0;
  int n_err = 0;
  int n_retired = 0;
  int m_drop = 0;
  logic [1:0] m_id [NC];
  logic       m_en [NC];
  word_t      exp_q [$];
  bit         rand_ready = 1'b0;

  int          mk;
  logic [15:0] mwant;
  word_t       mw;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_mask(input logic [1:0] tag, input logic [1:0] mode);
    logic [3:0] m = '0;
    for (int i = 0; i < NC; i++) begin
      case (mode)
        2'd0: m[i] = m_en[i] && (m_id[i] == tag);
        2'd1: m[i] = m_en[i];
        2'd2: m[i] = m_en[i] && (int'(tag) == i);
        default: m[i] = 1'b0;
      endcase
    end
    return m;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_drop = 0;
    for (int i = 0; i < NC; i++) begin
      m_id[i] = 2'(i);
      m_en[i] = 1'b1;
    end
  endtask

  task automatic model_accept(input logic [15:0] d, input logic [1:0] t, input logic [1:0] m);
    logic [3:0] mask = model_mask(t, m);
    if (mask == '0) begin
      if (m_drop < 65535) m_drop++;
    end else begin
      exp_q.push_back('{data: d, mask: mask});
    end
  endtask

  task automatic cfg_write(input logic [1:0] col, input logic [1:0] id, input logic en);
    cfg_we = 1'b1; cfg_col = col; cfg_id = id; cfg_en = en;
    tick();
    cfg_we = 1'b0;
    m_id[col] = id;
    m_en[col] = en;
  endtask

  task automatic push_word(input logic [15:0] d, input logic [1:0] t, input logic [1:0] m);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_tag = t; in_mode = m;
    while (in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("push_timeout", 32'(n < 100), 32'd1);
    if (n < 100) begin
      model_accept(d, t, m);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic try_push(input logic [15:0] d, input logic [1:0] t, input logic [1:0] m,
                          output bit acc);
    in_valid = 1'b1; in_data = d; in_tag = t; in_mode = m;
    acc = (in_ready === 1'b1);
    if (acc) model_accept(d, t, m);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < bound), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  // Every column handshake must hand over the oldest outstanding word aimed at that column.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) begin
        if (pe_valid[i] && pe_ready[i]) begin
          mk = -1;
          mwant = '0;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (mk < 0 && exp_q[j].mask[i]) mk = j;
          end
          if (mk >= 0) mwant = exp_q[mk].data;
          n_cmp++;
          assert (mk >= 0 && pe_data === mwant) else begin
            n_err++;
            $error("FAIL deliver_col%0d: observed %0h expected %0h (word outstanding=%0d)",
                   i, pe_data, mwant, mk >= 0);
          end
          if (mk >= 0) begin
            mw = exp_q[mk];
            mw.mask[i] = 1'b0;
            exp_q[mk] = mw;
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].mask == '0) begin
        void'(exp_q.pop_front());
        n_retired++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      pe_ready = 4'($urandom);
    end
  end

  initial begin
    bit acc;
    int n_acc;
    int r0;
    model_reset();

    // Reset defaults
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_pe_valid", 32'(pe_valid), 32'd0);
    check("rst_pe_data", 32'(pe_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Tag match to column 2, two-cycle latency, single-cycle valid
    pe_ready = 4'b1111;
    push_word(16'h1234, 2'd2, 2'b00);
    check("t1_valid_t1", 32'(pe_valid), 32'h0);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_valid_t2", 32'(pe_valid), 32'h4);
    check("t1_data", 32'(pe_data), 32'h1234);
    tick();
    check("t1_valid_t3", 32'(pe_valid), 32'h0);
    check("t1_busy_done", 32'(busy), 32'd0);

    // Broadcast under partial backpressure
    pe_ready = 4'b0101;
    push_word(16'hBEEF, 2'd0, 2'b01);
    tick();
    check("t2_valid_all", 32'(pe_valid), 32'hF);
    check("t2_data_a", 32'(pe_data), 32'hBEEF);
    tick();
    check("t2_valid_odd_a", 32'(pe_valid), 32'hA);
    check("t2_data_b", 32'(pe_data), 32'hBEEF);
    tick();
    check("t2_valid_odd_b", 32'(pe_valid), 32'hA);
    check("t2_data_c", 32'(pe_data), 32'hBEEF);
    check("t2_busy_stalled", 32'(busy), 32'd1);
    pe_ready = 4'b1111;
    tick();
    check("t2_valid_done", 32'(pe_valid), 32'h0);
    check("t2_busy_done", 32'(busy), 32'd0);

    // ID remap and column disable
    cfg_write(2'd0, 2'd3, 1'b1);
    cfg_write(2'd3, 2'd3, 1'b0);
    push_word(16'h0333, 2'd3, 2'b00);
    tick();
    check("t3_valid", 32'(pe_valid), 32'h1);
    check("t3_data", 32'(pe_data), 32'h0333);
    wait_idle(20);

    // Drops: unicast to a disabled column, then reserved mode
    push_word(16'h4444, 2'd3, 2'b10);
    push_word(16'h5555, 2'd1, 2'b11);
    repeat (3) tick();
    check("t4_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("t4_busy", 32'(busy), 32'd0);

    // FIFO full and pointer wrap
    do_reset();
    pe_ready = 4'b0000;
    n_acc = 0;
    r0 = n_retired;
    for (int k = 0; k < 6; k++) begin
      try_push(16'h5000 + 16'(k), 2'($urandom), 2'b01, acc);
      if (acc) n_acc++;
    end
    check("t5_accepted_stalled", 32'(n_acc), 32'd4);
    check("t5_in_ready_full", 32'(in_ready), 32'd0);
    check("t5_busy_full", 32'(busy), 32'd1);
    pe_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      push_word(16'h5100 + 16'(k), 2'($urandom), 2'b01);
    end
    wait_idle(200);
    check("t5_retired", 32'(n_retired - r0), 32'd12);

    // Randomized traffic, config changes only while the engine is idle
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        wait_idle(500);
        cfg_write(2'($urandom_range(0, 3)), 2'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      push_word(16'($urandom), 2'($urandom),
                ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
    end
    wait_idle(1000);
    rand_ready = 1'b0;
    tick();
    check("rand_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a stalled broadcast
    do_reset();
    pe_ready = 4'b0000;
    push_word(16'h6666, 2'd0, 2'b01);
    tick();
    check("t6_valid_before", 32'(pe_valid), 32'hF);
    rst = 1'b1;
    tick();
    check("t6_valid_rst", 32'(pe_valid), 32'h0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_drop_rst", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    model_reset();
    pe_ready = 4'b1111;
    push_word(16'h7777, 2'd1, 2'b00);
    tick();
    check("t6_valid_next", 32'(pe_valid), 32'h2);
    check("t6_data_next", 32'(pe_data), 32'h7777);
    wait_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
